branch_unit: RTL

- Parametrised RV32 control-transfer unit. Successor to the combinational jump controller.
- Resolves JAL, JALR and all six conditional branches. Comparisons are done locally on rs1/rs2 instead of ALU flags.
- Produces a link write-back and a registered redirect held under a valid/ready handshake with fetch.
- Flags misaligned targets and keeps saturating branch/taken statistics counters.
- Sits between decode/register-read and the PC/fetch stage.

---
 rtl/br_pkg.sv | 50 +++++
 rtl/br_cmp.sv | 37 +++
 rtl/branch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/br_pkg.sv
// ---------------------------------------------------------------------------
// br_pkg
// Shared types and constants for the RV32 control-transfer unit.
//   br_op_t  : 4-bit operation code presented by decode (9..15 act as NOP)
//   state_t  : redirect handshake state
//   LINK_OFS : offset from the issuing pc to the link (return) address
// Helper functions classify an op code as a jump or a conditional branch.
// ---------------------------------------------------------------------------
package br_pkg;

    typedef enum logic [3:0] {
        NOP  = 4'd0,
        JAL  = 4'd1,
        JALR = 4'd2,
        BEQ  = 4'd3,
        BNE  = 4'd4,
        BLT  = 4'd5,
        BGE  = 4'd6,
        BLTU = 4'd7,
        BGEU = 4'd8
    } br_op_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    localparam int LINK_OFS = 4;

    // Unconditional jumps write a link register.
    function automatic logic is_jump(input logic [3:0] op);
        logic res;
        case (op)
            JAL, JALR: res = 1'b1;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

    // The six conditional branches are the only ops that count in branch_cnt.
    function automatic logic is_cond_branch(input logic [3:0] op);
        logic res;
        case (op)
            BEQ, BNE, BLT, BGE, BLTU, BGEU: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/br_cmp.sv
// ---------------------------------------------------------------------------
// br_cmp
// Combinational branch-condition evaluator. Kept standalone so a future
// predictor can reuse the same decision logic.
// Ports:
//   op    in  4     operation code (br_op_t encoding)
//   rs1   in  XLEN  source operand 1
//   rs2   in  XLEN  source operand 2
//   taken out 1     op transfers control (jumps always, NOP/reserved never)
// ---------------------------------------------------------------------------
module br_cmp
    import br_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    // Decide whether the op redirects control flow.
    always_comb begin
        taken = 1'b0;
        case (op)
            JAL, JALR: taken = 1'b1;
            BEQ:       taken = (rs1 == rs2);
            BNE:       taken = (rs1 != rs2);
            BLT:       taken = ($signed(rs1) <  $signed(rs2));
            BGE:       taken = ($signed(rs1) >= $signed(rs2));
            BLTU:      taken = (rs1 <  rs2);
            BGEU:      taken = (rs1 >= rs2);
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// ---------------------------------------------------------------------------
// branch_unit
// RV32 control-transfer unit between decode/register-read and fetch.
// Resolves JAL, JALR and the six conditional branches, writes the link
// address, raises a misaligned-target trap, and holds a taken redirect under
// a valid/ready handshake with fetch. Saturating statistics counters track
// accepted conditional branches and redirects.
// Ports:
//   clk, nreset            clock, asynchronous active-low reset
//   ena                    gates issue acceptance only
//   issue_valid/ready      decode handshake (ready = ena && IDLE)
//   op, pc, imm, rs1, rs2  operation and operands
//   redir_valid/ready/pc   registered redirect to fetch
//   link_wr, link_data     one-cycle link write of pc+4 (jumps)
//   misalign, trap_addr    one-cycle trap pulse, held offending target
//   branch_cnt, taken_cnt  saturating statistics
// ---------------------------------------------------------------------------
module branch_unit
    import br_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             ena,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       op,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_pc,
    output logic             link_wr,
    output logic [XLEN-1:0]  link_data,
    output logic             misalign,
    output logic [XLEN-1:0]  trap_addr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [XLEN-1:0]  JALR_MASK = ~(XLEN'(1));
    localparam logic [XLEN-1:0]  LINK_INC  = XLEN'(LINK_OFS);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] res;
        if (c == CNT_MAX) begin
            res = c;
        end else begin
            res = c + CNT_W'(1);
        end
        return res;
    endfunction

    // Alignment check honours compressed (16-bit) instruction support.
    function automatic logic target_misaligned(input logic [XLEN-1:0] t);
        logic res;
        if (IALIGN == 16) begin
            res = t[0];
        end else begin
            res = |t[1:0];
        end
        return res;
    endfunction

    state_t           state_r, state_nxt_s;
    logic             idle_r;
    logic [XLEN-1:0]  redir_pc_r, redir_pc_nxt_s;
    logic             link_wr_r, link_wr_nxt_s;
    logic [XLEN-1:0]  link_data_r, link_data_nxt_s;
    logic             misalign_r, misalign_nxt_s;
    logic [XLEN-1:0]  trap_addr_r, trap_addr_nxt_s;
    logic [CNT_W-1:0] branch_cnt_r, branch_cnt_nxt_s;
    logic [CNT_W-1:0] taken_cnt_r, taken_cnt_nxt_s;

    logic             accept_s;
    logic             taken_s;
    logic             mis_s;
    logic [XLEN-1:0]  target_s;

    // idle_r mirrors "state is IDLE" but stays low while in reset, so
    // issue_ready reads 0 during reset regardless of ena.
    assign issue_ready = ena & idle_r;
    assign accept_s    = issue_valid & issue_ready;

    assign redir_valid = (state_r == REDIR);
    assign redir_pc    = redir_pc_r;
    assign link_wr     = link_wr_r;
    assign link_data   = link_data_r;
    assign misalign    = misalign_r;
    assign trap_addr   = trap_addr_r;
    assign branch_cnt  = branch_cnt_r;
    assign taken_cnt   = taken_cnt_r;

    br_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .op    (op),
        .rs1   (rs1),
        .rs2   (rs2),
        .taken (taken_s)
    );

    // Target adder: JALR is register-relative with bit 0 forced low.
    always_comb begin
        target_s = pc + imm;
        if (op == JALR) begin
            target_s = (rs1 + imm) & JALR_MASK;
        end else begin
            target_s = pc + imm;
        end
    end

    assign mis_s = taken_s & target_misaligned(target_s);

    // Next-state and next-output logic for the redirect handshake.
    always_comb begin
        state_nxt_s      = state_r;
        redir_pc_nxt_s   = redir_pc_r;
        link_wr_nxt_s    = 1'b0;
        link_data_nxt_s  = link_data_r;
        misalign_nxt_s   = 1'b0;
        trap_addr_nxt_s  = trap_addr_r;
        branch_cnt_nxt_s = branch_cnt_r;
        taken_cnt_nxt_s  = taken_cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (is_jump(op)) begin
                        link_wr_nxt_s   = 1'b1;
                        link_data_nxt_s = pc + LINK_INC;
                    end else begin
                        link_wr_nxt_s   = 1'b0;
                    end
                    if (is_cond_branch(op)) begin
                        branch_cnt_nxt_s = sat_inc(branch_cnt_r);
                    end else begin
                        branch_cnt_nxt_s = branch_cnt_r;
                    end
                    // A misaligned target traps instead of redirecting.
                    if (taken_s && !mis_s) begin
                        state_nxt_s     = REDIR;
                        redir_pc_nxt_s  = target_s;
                        taken_cnt_nxt_s = sat_inc(taken_cnt_r);
                    end else if (mis_s) begin
                        misalign_nxt_s  = 1'b1;
                        trap_addr_nxt_s = target_s;
                    end else begin
                        state_nxt_s     = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REDIR: begin
                // Fetch handshake completes independently of ena.
                if (redir_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REDIR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r      <= IDLE;
            idle_r       <= 1'b0;
            redir_pc_r   <= {XLEN{1'b0}};
            link_wr_r    <= 1'b0;
            link_data_r  <= {XLEN{1'b0}};
            misalign_r   <= 1'b0;
            trap_addr_r  <= {XLEN{1'b0}};
            branch_cnt_r <= {CNT_W{1'b0}};
            taken_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            idle_r       <= (state_nxt_s == IDLE);
            redir_pc_r   <= redir_pc_nxt_s;
            link_wr_r    <= link_wr_nxt_s;
            link_data_r  <= link_data_nxt_s;
            misalign_r   <= misalign_nxt_s;
            trap_addr_r  <= trap_addr_nxt_s;
            branch_cnt_r <= branch_cnt_nxt_s;
            taken_cnt_r  <= taken_cnt_nxt_s;
        end
    end

endmodule
